// File: rtl/operand_select_stage.sv
// rtl/operand_select_stage.sv - operand select stage: prefix-extended immediate decode with valid/ready handshake (option: OPSEL_IMM_SIGN_EXT_EN)
module operand_select_stage #(
    parameter int unsigned WORD_SIZE                  = 16,
    parameter logic [3:0]  DEFAULT_IMM_SELECTOR_VALUE = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic                 imm_flag,
    input  logic                 prefix_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           sel_a,
    output logic [3:0]           sel_b,
    output logic [WORD_SIZE-1:0] imm_value,
    output logic                 imm_ext,
    output logic                 prefix_dropped
);

    typedef enum logic {
        S_IDLE,
        S_PREFIX
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-9:0] prefix_hi_q, prefix_hi_d;
    logic                 out_valid_q, out_valid_d;
    logic [2:0]           sel_a_q, sel_a_d;
    logic [3:0]           sel_b_q, sel_b_d;
    logic [WORD_SIZE-1:0] imm_value_q, imm_value_d;
    logic                 imm_ext_q, imm_ext_d;
    logic                 prefix_dropped_q, prefix_dropped_d;

    logic                 accept;
    logic [WORD_SIZE-1:0] imm_short;
    logic                 unused_instr_bits;

    // A new instruction may enter whenever the output slot is empty or drains this cycle.
    assign in_ready = (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

`ifdef OPSEL_IMM_SIGN_EXT_EN
    assign imm_short = {{(WORD_SIZE-8){instruction[7]}}, instruction[7:0]};
`else
    assign imm_short = {{(WORD_SIZE-8){1'b0}}, instruction[7:0]};
`endif

    assign unused_instr_bits = ^{instruction[WORD_SIZE-1:11], instruction[3]};

    // Next-state and next-result decode; flush overrides everything.
    always_comb begin
        state_d          = state_q;
        prefix_hi_d      = prefix_hi_q;
        out_valid_d      = out_valid_q;
        sel_a_d          = sel_a_q;
        sel_b_d          = sel_b_q;
        imm_value_d      = imm_value_q;
        imm_ext_d        = imm_ext_q;
        prefix_dropped_d = 1'b0;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
            prefix_hi_d = '0;
        end else if (accept && prefix_flag) begin
            // Prefix words only stage upper immediate bits; the slot is free or draining.
            prefix_hi_d = instruction[WORD_SIZE-9:0];
            state_d     = S_PREFIX;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
            prefix_hi_d = '0;
            if (imm_flag) begin
                sel_a_d = instruction[10:8];
                sel_b_d = DEFAULT_IMM_SELECTOR_VALUE;
                if (state_q == S_PREFIX) begin
                    imm_value_d = {prefix_hi_q, instruction[7:0]};
                    imm_ext_d   = 1'b1;
                end else begin
                    imm_value_d = imm_short;
                    imm_ext_d   = 1'b0;
                end
            end else begin
                sel_a_d          = instruction[6:4];
                sel_b_d          = {1'b0, instruction[2:0]};
                imm_value_d      = '0;
                imm_ext_d        = 1'b0;
                prefix_dropped_d = (state_q == S_PREFIX);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State machine and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            prefix_hi_q      <= '0;
            out_valid_q      <= 1'b0;
            sel_a_q          <= '0;
            sel_b_q          <= '0;
            imm_value_q      <= '0;
            imm_ext_q        <= 1'b0;
            prefix_dropped_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            prefix_hi_q      <= prefix_hi_d;
            out_valid_q      <= out_valid_d;
            sel_a_q          <= sel_a_d;
            sel_b_q          <= sel_b_d;
            imm_value_q      <= imm_value_d;
            imm_ext_q        <= imm_ext_d;
            prefix_dropped_q <= prefix_dropped_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign sel_a          = sel_a_q;
    assign sel_b          = sel_b_q;
    assign imm_value      = imm_value_q;
    assign imm_ext        = imm_ext_q;
    assign prefix_dropped = prefix_dropped_q;

endmodule
